// File: rtl/pcs_pkg.sv
// Shared package for the 64b/66b PCS transmit path.
// Holds XGMII lane geometry, XGMII control characters, the 7-bit control codes,
// block-type and sync-header constants, the transmit FSM state type, the block
// class type and small helpers shared by the classifier and the encoder top.
package pcs_pkg;

    localparam int unsigned N_CHANNELS = 4;
    localparam int unsigned W_BYTE     = 8;
    localparam int unsigned N_LANES    = 2 * N_CHANNELS;
    localparam int unsigned W_BLOCK    = N_LANES * W_BYTE;

    // XGMII control characters
    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;

    // 7-bit control codes carried inside control blocks
    localparam logic [6:0] CODE_IDLE  = 7'h00;
    localparam logic [6:0] CODE_ERROR = 7'h1E;

    // Block types
    localparam logic [7:0] BT_C  = 8'h1E;
    localparam logic [7:0] BT_S0 = 8'h78;
    localparam logic [7:0] BT_S4 = 8'h33;

    // Sync headers
    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    // Error block payload: C-type block with every lane coded as error
    localparam logic [W_BLOCK-1:0] EBLOCK_PAYLOAD = {{N_LANES{CODE_ERROR}}, BT_C};

    typedef enum logic [2:0] {StInit, StC, StD, StT, StE} tx_state_e;

    typedef enum logic [2:0] {CLS_C, CLS_S, CLS_D, CLS_T, CLS_E} blk_class_e;

    // Block type for a terminate block whose TERM sits in lane k
    function automatic logic [7:0] bt_term(input logic [2:0] k);
        logic [7:0] bt;
        case (k)
            3'd0:    bt = 8'h87;
            3'd1:    bt = 8'h99;
            3'd2:    bt = 8'hAA;
            3'd3:    bt = 8'hB4;
            3'd4:    bt = 8'hCC;
            3'd5:    bt = 8'hD2;
            3'd6:    bt = 8'hE1;
            default: bt = 8'hFF;
        endcase
        return bt;
    endfunction

    // Only IDLE and ERROR may appear as plain control lanes inside a block
    function automatic logic is_legal_ctrl(input logic ctrl, input logic [7:0] data);
        return ctrl && ((data == XGMII_IDLE) || (data == XGMII_ERROR));
    endfunction

    function automatic logic [6:0] ctrl_code(input logic [7:0] data);
        return (data == XGMII_ERROR) ? CODE_ERROR : CODE_IDLE;
    endfunction

    // Transmit state machine transition, evaluated once per block
    function automatic tx_state_e tx_next_state(input tx_state_e st, input blk_class_e cls);
        tx_state_e nxt;
        nxt = StE;
        case (st)
            StInit, StC, StT: begin
                if (cls == CLS_C)      nxt = StC;
                else if (cls == CLS_S) nxt = StD;
            end
            StD: begin
                if (cls == CLS_D)      nxt = StD;
                else if (cls == CLS_T) nxt = StT;
            end
            StE: begin
                if (cls == CLS_D)      nxt = StD;
                else if (cls == CLS_C) nxt = StC;
                else if (cls == CLS_T) nxt = StT;
            end
            default: nxt = StE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pcs_tx_encoder_if.sv
// XGMII-in / block-out bus of the PCS transmit encoder.
//   i_clk_en      : transfer qualifier
//   i_xgmii_ctrl  : per-lane control flags (lane 0 first on the wire)
//   i_xgmii_data  : per-lane bytes, lane i at [8*i +: 8]
//   o_block_valid : one-cycle new-block strobe
//   o_header      : 2-bit sync header
//   o_payload     : 64-bit block payload, byte 0 at [7:0]
// master drives the XGMII side, slave is the encoder.
interface pcs_tx_encoder_if;
    import pcs_pkg::*;

    logic                         i_clk_en;
    logic [N_CHANNELS-1:0]        i_xgmii_ctrl;
    logic [N_CHANNELS*W_BYTE-1:0] i_xgmii_data;
    logic                         o_block_valid;
    logic [1:0]                   o_header;
    logic [W_BLOCK-1:0]           o_payload;

    modport master (
        output i_clk_en, i_xgmii_ctrl, i_xgmii_data,
        input  o_block_valid, o_header, o_payload
    );

    modport slave (
        input  i_clk_en, i_xgmii_ctrl, i_xgmii_data,
        output o_block_valid, o_header, o_payload
    );

endinterface

// File: rtl/pcs_tx_block_classify.sv
// Combinational 64b/66b block classifier and encoder.
//   ctrl_i    : 8 lane control flags, lane 0 first
//   data_i    : 8 lane bytes, lane i at [8*i +: 8]
//   cls_o     : block class (C, S, D, T, E)
//   header_o  : sync header for the encoded block
//   payload_o : encoded 64-bit payload (EBLOCK for class E)
module pcs_tx_block_classify
    import pcs_pkg::*;
(
    input  logic [N_LANES-1:0] ctrl_i,
    input  logic [W_BLOCK-1:0] data_i,
    output blk_class_e         cls_o,
    output logic [1:0]         header_o,
    output logic [W_BLOCK-1:0] payload_o
);

    logic [N_LANES-1:0] legal;
    logic [N_LANES-1:0] start;
    logic [N_LANES-1:0] term;
    logic [N_LANES-1:0] t_match;
    logic [6:0]         code [N_LANES];

    always_comb begin
        for (int i = 0; i < N_LANES; i++) begin
            legal[i] = is_legal_ctrl(ctrl_i[i], data_i[W_BYTE*i +: W_BYTE]);
            start[i] = ctrl_i[i] && (data_i[W_BYTE*i +: W_BYTE] == XGMII_START);
            term[i]  = ctrl_i[i] && (data_i[W_BYTE*i +: W_BYTE] == XGMII_TERM);
            code[i]  = ctrl_code(data_i[W_BYTE*i +: W_BYTE]);
        end
        // Tk: data before lane k, TERM at k, legal control after k
        for (int k = 0; k < N_LANES; k++) begin
            t_match[k] = term[k];
            for (int j = 0; j < N_LANES; j++) begin
                if (j < k)      t_match[k] = t_match[k] & ~ctrl_i[j];
                else if (j > k) t_match[k] = t_match[k] & legal[j];
            end
        end
    end

    always_comb begin
        cls_o     = CLS_E;
        header_o  = HDR_CTRL;
        payload_o = EBLOCK_PAYLOAD;
        if (ctrl_i == '0) begin
            cls_o     = CLS_D;
            header_o  = HDR_DATA;
            payload_o = data_i;
        end else if (&legal) begin
            cls_o          = CLS_C;
            payload_o      = '0;
            payload_o[7:0] = BT_C;
            for (int j = 0; j < N_LANES; j++) payload_o[8+7*j +: 7] = code[j];
        end else if ((ctrl_i == 8'h01) && start[0]) begin
            cls_o     = CLS_S;
            payload_o = {data_i[W_BLOCK-1:8], BT_S0};
        end else if ((ctrl_i == 8'h1F) && (&legal[3:0]) && start[4]) begin
            cls_o          = CLS_S;
            payload_o      = '0;
            payload_o[7:0] = BT_S4;
            for (int j = 0; j < 4; j++) payload_o[8+7*j +: 7] = code[j];
            payload_o[63:40] = data_i[63:40];
        end else if (|t_match) begin
            cls_o     = CLS_T;
            payload_o = '0;
            // At most one k can match: a later TERM is not legal control
            for (int k = 0; k < N_LANES; k++) begin
                if (t_match[k]) begin
                    payload_o[7:0] = bt_term(3'(k));
                    for (int j = 0; j < N_LANES; j++) begin
                        if (j < k) begin
                            payload_o[8*(j+1) +: 8] = data_i[8*j +: 8];
                        end else if (j > k) begin
                            payload_o[8+7*j +: 7] = code[j];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pcs_tx_encoder.sv
// 64b/66b transmit encoder: packs two enabled 32-bit XGMII transfers into one
// 64-bit block, classifies it, runs the transmit state machine and registers
// the sync header and payload with a one-cycle valid strobe.
//   i_clk   : TX clock
//   i_reset : asynchronous active-high reset
//   bus     : XGMII input and encoded block output (slave side)
module pcs_tx_encoder
    import pcs_pkg::*;
(
    input logic              i_clk,
    input logic              i_reset,
    pcs_tx_encoder_if.slave  bus
);

    logic                         phase_q, phase_d;
    logic [N_CHANNELS-1:0]        ctrl_lo_q, ctrl_lo_d;
    logic [N_CHANNELS*W_BYTE-1:0] data_lo_q, data_lo_d;
    tx_state_e                    state_q, state_d;
    logic                         valid_q, valid_d;
    logic [1:0]                   header_q, header_d;
    logic [W_BLOCK-1:0]           payload_q, payload_d;

    blk_class_e                   cls;
    logic [1:0]                   cls_header;
    logic [W_BLOCK-1:0]           cls_payload;

    // Stored half supplies lanes 0-3, live transfer supplies lanes 4-7
    pcs_tx_block_classify u_classify (
        .ctrl_i    ({bus.i_xgmii_ctrl, ctrl_lo_q}),
        .data_i    ({bus.i_xgmii_data, data_lo_q}),
        .cls_o     (cls),
        .header_o  (cls_header),
        .payload_o (cls_payload)
    );

    always_comb begin
        phase_d   = phase_q;
        ctrl_lo_d = ctrl_lo_q;
        data_lo_d = data_lo_q;
        state_d   = state_q;
        valid_d   = 1'b0;
        header_d  = header_q;
        payload_d = payload_q;
        if (bus.i_clk_en) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                ctrl_lo_d = bus.i_xgmii_ctrl;
                data_lo_d = bus.i_xgmii_data;
            end else begin
                state_d = tx_next_state(state_q, cls);
                valid_d = 1'b1;
                if (state_d == StE) begin
                    header_d  = HDR_CTRL;
                    payload_d = EBLOCK_PAYLOAD;
                end else begin
                    header_d  = cls_header;
                    payload_d = cls_payload;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            phase_q   <= 1'b0;
            ctrl_lo_q <= '0;
            data_lo_q <= '0;
            state_q   <= StInit;
            valid_q   <= 1'b0;
            header_q  <= '0;
            payload_q <= '0;
        end else begin
            phase_q   <= phase_d;
            ctrl_lo_q <= ctrl_lo_d;
            data_lo_q <= data_lo_d;
            state_q   <= state_d;
            valid_q   <= valid_d;
            header_q  <= header_d;
            payload_q <= payload_d;
        end
    end

    assign bus.o_block_valid = valid_q;
    assign bus.o_header      = header_q;
    assign bus.o_payload     = payload_q;

endmodule

// File: tb/tb_pcs_tx_encoder.sv
// Directed self-checking bench for pcs_tx_encoder.
module tb_pcs_tx_encoder;
    import pcs_pkg::*;

    localparam logic [63:0] EXP_IDLE   = 64'h0000_0000_0000_001E;
    localparam logic [63:0] EXP_EBLOCK = 64'h3C78_F1E3_C78F_1E1E;
    localparam logic [63:0] IDLE8      = 64'h0707_0707_0707_0707;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    pcs_tx_encoder_if bus ();

    pcs_tx_encoder dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // One transfer; returns #1 after the active edge
    task automatic xfer(input logic en, input logic [3:0] c, input logic [31:0] d);
        bus.i_clk_en     = en;
        bus.i_xgmii_ctrl = c;
        bus.i_xgmii_data = d;
        @(posedge clk);
        #1;
    endtask

    // Two enabled transfers; v_mid is the strobe seen after the first one
    task automatic send_block(input logic [7:0] c, input logic [63:0] d, output logic v_mid);
        xfer(1'b1, c[3:0], d[31:0]);
        v_mid = bus.o_block_valid;
        xfer(1'b1, c[7:4], d[63:32]);
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.o_block_valid !== 1'b0)
            $display("FAIL rst_valid: got %b want 0", bus.o_block_valid);
        else n_pass++;
        n_checks++;
        if (bus.o_header !== 2'b00) $display("FAIL rst_header: got %b want 00", bus.o_header);
        else n_pass++;
        n_checks++;
        if (bus.o_payload !== 64'h0) $display("FAIL rst_payload: got %h want 0", bus.o_payload);
        else n_pass++;
    endtask

    task automatic test_idle();
        logic v;
        for (int i = 0; i < 3; i++) begin
            send_block(8'hFF, IDLE8, v);
            n_checks++;
            if (v !== 1'b0) $display("FAIL idle_mid_valid[%0d]: got %b want 0", i, v);
            else n_pass++;
            n_checks++;
            if (bus.o_block_valid !== 1'b1)
                $display("FAIL idle_valid[%0d]: got %b want 1", i, bus.o_block_valid);
            else n_pass++;
            n_checks++;
            if (bus.o_header !== 2'b10)
                $display("FAIL idle_header[%0d]: got %b want 10", i, bus.o_header);
            else n_pass++;
            n_checks++;
            if (bus.o_payload !== EXP_IDLE)
                $display("FAIL idle_payload[%0d]: got %h want %h", i, bus.o_payload, EXP_IDLE);
            else n_pass++;
        end
    endtask

    task automatic test_start_s0();
        logic v;
        send_block(8'h01, 64'hD555_5555_5555_55FB, v);
        n_checks++;
        if (bus.o_header !== 2'b10) $display("FAIL s0_header: got %b want 10", bus.o_header);
        else n_pass++;
        n_checks++;
        if (bus.o_payload !== 64'hD555_5555_5555_5578)
            $display("FAIL s0_payload: got %h want d555555555555578", bus.o_payload);
        else n_pass++;
        send_block(8'h00, 64'h0807_0605_0403_0201, v);
        n_checks++;
        if (bus.o_header !== 2'b01) $display("FAIL data_header: got %b want 01", bus.o_header);
        else n_pass++;
        n_checks++;
        if (bus.o_payload !== 64'h0807_0605_0403_0201)
            $display("FAIL data_payload: got %h want 0807060504030201", bus.o_payload);
        else n_pass++;
    endtask

    task automatic test_terminate();
        logic v;
        send_block(8'hF8, 64'h0707_0707_FD33_2211, v);
        n_checks++;
        if (bus.o_header !== 2'b10) $display("FAIL t3_header: got %b want 10", bus.o_header);
        else n_pass++;
        n_checks++;
        if (bus.o_payload !== 64'h0000_0000_3322_11B4)
            $display("FAIL t3_payload: got %h want 00000000332211b4", bus.o_payload);
        else n_pass++;
        send_block(8'hFF, IDLE8, v);
        n_checks++;
        if (bus.o_payload !== EXP_IDLE)
            $display("FAIL t3_next_idle: got %h want %h", bus.o_payload, EXP_IDLE);
        else n_pass++;
    endtask

    task automatic test_start_s4();
        logic v;
        send_block(8'h1F, 64'hC3B2_A1FB_0707_0707, v);
        n_checks++;
        if (bus.o_payload !== 64'hC3B2_A100_0000_0033)
            $display("FAIL s4_payload: got %h want c3b2a10000000033", bus.o_payload);
        else n_pass++;
        send_block(8'hFF, 64'h0707_0707_0707_07FD, v);
        n_checks++;
        if (bus.o_payload !== 64'h0000_0000_0000_0087)
            $display("FAIL t0_payload: got %h want 0000000000000087", bus.o_payload);
        else n_pass++;
        // Data right after a terminate is caught one block late
        send_block(8'h00, 64'h1122_3344_5566_7788, v);
        n_checks++;
        if (bus.o_header !== 2'b10) $display("FAIL t_then_d_header: got %b want 10", bus.o_header);
        else n_pass++;
        n_checks++;
        if (bus.o_payload !== EXP_EBLOCK)
            $display("FAIL t_then_d_payload: got %h want %h", bus.o_payload, EXP_EBLOCK);
        else n_pass++;
        send_block(8'hFF, IDLE8, v);
        n_checks++;
        if (bus.o_payload !== EXP_IDLE)
            $display("FAIL e_then_c_payload: got %h want %h", bus.o_payload, EXP_IDLE);
        else n_pass++;
    endtask

    task automatic test_error();
        logic v;
        send_block(8'h00, 64'hA1A2_A3A4_A5A6_A7A8, v);
        n_checks++;
        if (bus.o_header !== 2'b10) $display("FAIL c_then_d_header: got %b want 10", bus.o_header);
        else n_pass++;
        n_checks++;
        if (bus.o_payload !== EXP_EBLOCK)
            $display("FAIL c_then_d_payload: got %h want %h", bus.o_payload, EXP_EBLOCK);
        else n_pass++;
        send_block(8'hFF, IDLE8, v);
        n_checks++;
        if (bus.o_payload !== EXP_IDLE)
            $display("FAIL err_recover_c: got %h want %h", bus.o_payload, EXP_IDLE);
        else n_pass++;
        send_block(8'h01, 64'h1615_1413_1211_10FB, v);
        n_checks++;
        if (bus.o_payload !== 64'h1615_1413_1211_1078)
            $display("FAIL err_recover_s0: got %h want 1615141312111078", bus.o_payload);
        else n_pass++;
        // START in lane 2 is never legal
        send_block(8'h04, 64'h7766_5544_33FB_1100, v);
        n_checks++;
        if (bus.o_payload !== EXP_EBLOCK)
            $display("FAIL start_lane2: got %h want %h", bus.o_payload, EXP_EBLOCK);
        else n_pass++;
        send_block(8'hFF, IDLE8, v);
        n_checks++;
        if (bus.o_payload !== EXP_IDLE)
            $display("FAIL err_to_idle: got %h want %h", bus.o_payload, EXP_IDLE);
        else n_pass++;
    endtask

    task automatic test_clk_en();
        logic [3:0] exp_v;
        exp_v = 4'b0100;
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 4; s++) begin
                if (s[0]) xfer(1'b0, 4'h0, 32'hDEAD_BEEF);
                else      xfer(1'b1, 4'hF, 32'h0707_0707);
                n_checks++;
                if (bus.o_block_valid !== exp_v[s])
                    $display("FAIL en_valid[%0d.%0d]: got %b want %b", r, s, bus.o_block_valid,
                             exp_v[s]);
                else n_pass++;
                n_checks++;
                if (bus.o_payload !== EXP_IDLE)
                    $display("FAIL en_payload[%0d.%0d]: got %h want %h", r, s, bus.o_payload,
                             EXP_IDLE);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_block();
        logic v;
        xfer(1'b1, 4'h0, 32'hAABB_CCDD);
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.o_header !== 2'b00) $display("FAIL mid_rst_header: got %b want 00", bus.o_header);
        else n_pass++;
        n_checks++;
        if (bus.o_payload !== 64'h0) $display("FAIL mid_rst_payload: got %h want 0", bus.o_payload);
        else n_pass++;
        xfer(1'b1, 4'hF, 32'h0707_0707);
        n_checks++;
        if (bus.o_block_valid !== 1'b0)
            $display("FAIL mid_rst_valid: got %b want 0", bus.o_block_valid);
        else n_pass++;
        rst = 1'b0;
        send_block(8'hFF, IDLE8, v);
        n_checks++;
        if (v !== 1'b0) $display("FAIL post_rst_first: got %b want 0", v);
        else n_pass++;
        n_checks++;
        if (bus.o_block_valid !== 1'b1)
            $display("FAIL post_rst_second: got %b want 1", bus.o_block_valid);
        else n_pass++;
        n_checks++;
        if (bus.o_payload !== EXP_IDLE)
            $display("FAIL post_rst_payload: got %h want %h", bus.o_payload, EXP_IDLE);
        else n_pass++;
    endtask

    initial begin
        rst              = 1'b1;
        bus.i_clk_en     = 1'b0;
        bus.i_xgmii_ctrl = 4'hF;
        bus.i_xgmii_data = 32'h0707_0707;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_idle();
        test_start_s0();
        test_terminate();
        test_start_s4();
        test_error();
        test_clk_en();
        test_reset_mid_block();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pcs_tx_encoder.md
Name: pcs_tx_encoder

Overview:
- 64b/66b transmit encoder on the PCS side of the TX XGMII link; it consumes the 4-lane XGMII stream the MAC transmitter produces.
- Each pair of clock-enabled 32-bit XGMII transfers is packed into one 64-bit block, classified, and emitted as a 2-bit sync header plus a 64-bit payload.
- Error blocks are substituted for illegal sequences, using the standard transmit state machine.
- The output goes unscrambled to the downstream scrambler/gearbox.

Parameters:
- None. Widths come from the shared package: N_CHANNELS = 4, W_BYTE = 8. Only 4 lanes are supported.

Ports:
- i_clk  in  1  TX clock
- i_reset  in  1  asynchronous, active-high reset
- i_clk_en  in  1  qualifies every input transfer; phase advances only when it is high
- i_xgmii_ctrl  in  N_CHANNELS  per-lane control flag; lane 0 is the first byte on the wire
- i_xgmii_data  in  N_CHANNELS x W_BYTE  per-lane byte
- o_block_valid  out  1  one-cycle strobe marking a new block
- o_header  out  2  sync header: 2'b01 = data block, 2'b10 = control block
- o_payload  out  64  block payload; byte 0 is [7:0]; for control blocks, [7:0] holds the block type

Behaviour:
- Reset values: o_block_valid=0, o_header=0, o_payload=0, phase=0, state=INIT.
- Packing: a 1-bit phase toggles on each i_clk_en.
  - phase 0 stores the transfer as block lanes 0-3.
  - phase 1 supplies lanes 4-7 and triggers encoding.
- Latency: outputs are registered. o_block_valid is high for exactly one i_clk cycle, the cycle after the phase-1 enable cycle. Outputs hold their value between strobes.
- Characters: IDLE 0x07, START 0xFB, TERM 0xFD, ERROR 0xFE.
  - 7-bit codes: idle 0x00, error 0x1E.
  - A control lane is "legal" if it is IDLE or ERROR.
- Classification of the 8-lane block:
  - D: all ctrl = 0. Header 01, payload = the 8 data bytes.
  - C: all ctrl = 1 and all lanes legal. Type 0x1E, then eight 7-bit codes.
  - S0: lane 0 = START, lanes 1-7 data. Type 0x78, then D1..D7.
  - S4: lanes 0-3 legal control, lane 4 = START, lanes 5-7 data. Type 0x33, then C0..C3 7-bit codes, 4 zero bits, D5..D7.
  - Tk (k = 0..7): lanes 0..k-1 data, lane k = TERM, lanes k+1..7 legal control.
    - Types by k: 0x87, 0x99, 0xAA, 0xB4, 0xCC, 0xD2, 0xE1, 0xFF.
    - Payload: D0..Dk-1, then zero pad bits, then the 7-bit codes of the remaining lanes (none for k=7).
  - E: anything else. Includes START outside lane 0/4, ordered sets, and non-idle/error control codes.
- EBLOCK: header 10, type 0x1E, all eight 7-bit codes = 0x1E.
- State machine, evaluated once per block:
  - INIT: C→C, S→D, else →E.
  - C: C→C, S→D, else →E.
  - D: D→D, T→T, else →E.
  - T: C→C, S→D, else →E.
  - E: D→D, C→C, T→T, else →E.
- Output rule: the transition into a legal state emits the encoded block; entering E emits EBLOCK.
- Lookahead: the next block after a T must be C or S. This is enforced one block late (the T is sent; the following illegal block becomes EBLOCK).
- Simultaneous events:
  - Reset mid-block discards the stored half, forces phase=0, and produces no strobe.
  - i_clk_en low holds all state.
- Block payload is 8 lanes = 64 bits. The header is not counted in the payload.

Decomposition:
- Shared package pcs_pkg holds:
  - XGMII character constants and the 7-bit control codes.
  - Block-type constants and sync-header constants.
  - typedef enum for the state (INIT, C, D, T, E).
  - typedef enum for the block class (CLS_C, CLS_S, CLS_D, CLS_T, CLS_E).
- N_CHANNELS and W_BYTE stay in the existing shared package.
- Sub-module pcs_tx_block_classify: purely combinational. It takes 8 ctrl/data lanes and returns the class plus the encoded header and payload. The top level keeps the phase, half-block register, FSM and output registers.

Test Plan:
- Reset, then a continuous idle stream (ctrl 4'hF, data 0x07 ×4, i_clk_en=1) → strobe every 2nd cycle; header 10, payload[7:0]=0x1E, payload[63:8]=0.
- Idle, START in lane 0 at phase 0, data 0x55.., 0xD5, then 0x01..0x08 → first block header 10, type 0x78, D1..D7 = 0x55×6, 0xD5; next block header 01, payload bytes 0x01..0x08.
- START arriving at phase 1 (lanes 0-3 idle) → type 0x33, C0..C3 = 0x00, payload[39:32]=0.
- Frame ending with 3 data bytes then TERM in block lane 3 → type 0xB4, D0..D2 preserved, remaining codes 0x00; next idle block → type 0x1E.
- Data block directly after C (no START) → EBLOCK (all codes 0x1E); next S0 block is encoded normally.
- i_clk_en toggling 1-0-1-0, plus reset asserted after phase 0 → strobes track enable count; no strobe from the discarded half; after release, the first strobe follows two enabled transfers.
